// File: rtl/pong_game_if.sv
// Pong game I/O bundle: frame/button inputs toward the game core, display state back out.
interface pong_game_if;
  logic        frame_tick;
  logic        start;
  logic        p1_up;
  logic        p1_dn;
  logic        p2_up;
  logic        p2_dn;
  logic [19:0] ball;
  logic [19:0] ppos;
  logic [7:0]  score;
  logic        game_over;

  modport master (
    output frame_tick, start, p1_up, p1_dn, p2_up, p2_dn,
    input  ball, ppos, score, game_over
  );

  modport slave (
    input  frame_tick, start, p1_up, p1_dn, p2_up, p2_dn,
    output ball, ppos, score, game_over
  );
endinterface

// File: rtl/pong_game.sv
// Pong game core: serve/play/game-over FSM, ball kinematics with wall and paddle
// reflection, BCD scoring and saturating paddles, all advanced once per frame tick.
module pong_game #(
  parameter int SERVE_FRAMES = 60,
  parameter int BALL_SPEED   = 2,
  parameter int PAD_SPEED    = 4,
  parameter int WIN_SCORE    = 9
) (
  input  logic      clk,
  input  logic      rst,
  pong_game_if.slave bus
);

  localparam int CW = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES);
  localparam logic [CW-1:0]      CNT_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [9:0]         X_C      = 10'd324;
  localparam logic [9:0]         Y_C      = 10'd303;
  localparam logic [9:0]         P_RST    = 10'd147;
  localparam logic [9:0]         P_MAX    = 10'd294;
  localparam logic [9:0]         PS       = 10'(PAD_SPEED);
  localparam logic signed [10:0] BS       = 11'(BALL_SPEED);
  localparam logic [3:0]         WIN      = 4'(WIN_SCORE);

  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, GAMEOVER = 2'd2} state_t;

  state_t          state, state_nx;
  logic [9:0]      x, y, p1, p2, x_nx, y_nx, p1_nx, p2_nx;
  logic            dx_neg, dy_neg, dx_neg_nx, dy_neg_nx;
  logic [3:0]      sl, sr, sl_nx, sr_nx, sl_inc, sr_inc;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            go;
  logic signed [10:0] xn, yn;
  logic [10:0]     yw;
  logic            hit_l, hit_r, miss_l, miss_r, win;

  function automatic logic [9:0] pad_step(input logic [9:0] p, input logic up, input logic dn);
    if (up && !dn)      return (p < PS) ? 10'd0 : p - PS;
    else if (dn && !up) return (p > P_MAX - PS) ? P_MAX : p + PS;
    else                return p;
  endfunction

  // 11-bit signed ball arithmetic so an overshoot past either edge is seen before clamping
  always_comb begin
    xn     = dx_neg ? $signed({1'b0, x}) - BS : $signed({1'b0, x}) + BS;
    yn     = dy_neg ? $signed({1'b0, y}) - BS : $signed({1'b0, y}) + BS;
    yw     = {1'b0, y};
    hit_l  = dx_neg && (xn <= 11'sd31) && (xn > 11'sd8) &&
             (yw - 11'd1 >= 11'd129 + {1'b0, p1}) && (yw - 11'd7 <= 11'd175 + {1'b0, p1});
    hit_r  = !dx_neg && (xn >= 11'sd617) && (xn < 11'sd639) &&
             (yw - 11'd1 >= 11'd129 + {1'b0, p2}) && (yw - 11'd7 <= 11'd175 + {1'b0, p2});
    miss_l = (xn <= 11'sd8);
    miss_r = (xn >= 11'sd639);
    sl_inc = (sl >= WIN) ? sl : sl + 4'd1;
    sr_inc = (sr >= WIN) ? sr : sr + 4'd1;
    win    = (miss_r && sl_inc == WIN) || (miss_l && sr_inc == WIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SERVE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SERVE:    if (bus.frame_tick && cnt == CNT_LAST) state_nx = PLAY;
      PLAY:     if (bus.frame_tick && (miss_l || miss_r)) state_nx = win ? GAMEOVER : SERVE;
      GAMEOVER: if (bus.start) state_nx = SERVE;
      default:  state_nx = SERVE;
    endcase
  end

  always_comb begin
    x_nx      = x;
    y_nx      = y;
    dx_neg_nx = dx_neg;
    dy_neg_nx = dy_neg;
    p1_nx     = p1;
    p2_nx     = p2;
    sl_nx     = sl;
    sr_nx     = sr;
    cnt_nx    = cnt;
    case (state)
      SERVE: if (bus.frame_tick) begin
        cnt_nx = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        x_nx   = X_C;
        y_nx   = Y_C;
        p1_nx  = pad_step(p1, bus.p1_up, bus.p1_dn);
        p2_nx  = pad_step(p2, bus.p2_up, bus.p2_dn);
      end
      PLAY: if (bus.frame_tick) begin
        p1_nx = pad_step(p1, bus.p1_up, bus.p1_dn);
        p2_nx = pad_step(p2, bus.p2_up, bus.p2_dn);
        if (miss_l || miss_r) begin
          // the next serve heads toward the player who just lost the point
          x_nx      = X_C;
          y_nx      = Y_C;
          dx_neg_nx = miss_l;
          if (miss_l) sr_nx = sr_inc;
          else        sl_nx = sl_inc;
        end else begin
          if (hit_l) begin
            x_nx      = 10'd32;
            dx_neg_nx = 1'b0;
          end else if (hit_r) begin
            x_nx      = 10'd616;
            dx_neg_nx = 1'b1;
          end else begin
            x_nx = xn[9:0];
          end
          if (yn <= 11'sd137) begin
            y_nx      = 10'd137;
            dy_neg_nx = 1'b0;
          end else if (yn >= 11'sd470) begin
            y_nx      = 10'd470;
            dy_neg_nx = 1'b1;
          end else begin
            y_nx = yn[9:0];
          end
        end
      end
      GAMEOVER: if (bus.start) begin
        sl_nx  = 4'd0;
        sr_nx  = 4'd0;
        cnt_nx = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x      <= X_C;
      y      <= Y_C;
      dx_neg <= 1'b0;
      dy_neg <= 1'b0;
      p1     <= P_RST;
      p2     <= P_RST;
      sl     <= 4'd0;
      sr     <= 4'd0;
      cnt    <= '0;
      go     <= 1'b0;
    end else begin
      x      <= x_nx;
      y      <= y_nx;
      dx_neg <= dx_neg_nx;
      dy_neg <= dy_neg_nx;
      p1     <= p1_nx;
      p2     <= p2_nx;
      sl     <= sl_nx;
      sr     <= sr_nx;
      cnt    <= cnt_nx;
      go     <= (state_nx == GAMEOVER);
    end
  end

  assign bus.ball      = {y, x};
  assign bus.ppos      = {p2, p1};
  assign bus.score     = {sr, sl};
  assign bus.game_over = go;

endmodule

// File: tb/tb_pong_game.sv
// Directed bench for pong_game: serve timing, walls, paddle hits and misses,
// paddle saturation, game over / restart and asynchronous reset.
module tb_pong_game;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pong_game_if bus();
  pong_game dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [19:0] xy(input int x, input int y);
    return {10'(y), 10'(x)};
  endfunction

  function automatic logic [19:0] pp(input int p2, input int p1);
    return {10'(p2), 10'(p1)};
  endfunction

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // tick pulse is one clk wide, followed by an idle clk; returns on a falling edge
  task automatic tick();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.p1_up = 1'b0; bus.p1_dn = 1'b0;
    bus.p2_up = 1'b0; bus.p2_dn = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ball", bus.ball, xy(324, 303));
    chk("rst_ppos", bus.ppos, pp(147, 147));
    chk("rst_score", {12'd0, bus.score}, 20'h00);
    chk("rst_go", {19'd0, bus.game_over}, 20'd0);
    rst = 1'b0;

    // rally 1: both buttons on each side cancel; serve lasts 60 ticks
    bus.p1_up = 1'b1; bus.p1_dn = 1'b1; bus.p2_up = 1'b1; bus.p2_dn = 1'b1;
    ticks(5);
    chk("both_btn", bus.ppos, pp(147, 147));
    bus.p1_up = 1'b0; bus.p1_dn = 1'b0; bus.p2_up = 1'b0; bus.p2_dn = 1'b0;
    ticks(55);
    chk("serve_hold", bus.ball, xy(324, 303));
    tick();
    chk("first_move", bus.ball, xy(326, 305));
    ticks(83);
    chk("bot_wall", bus.ball, xy(492, 470));
    tick();
    chk("bot_wall_after", bus.ball, xy(494, 468));
    ticks(70);
    chk("r_pad_edge_miss", bus.ball, xy(634, 328));
    tick();
    chk("r_pad_hit", bus.ball, xy(616, 326));
    ticks(94);
    chk("y138", bus.ball, xy(428, 138));
    tick();
    chk("top_wall", bus.ball, xy(426, 137));
    tick();
    chk("top_wall_after", bus.ball, xy(424, 139));
    ticks(207);
    chk("l_miss_before", bus.ball, xy(10, 388));
    tick();
    chk("l_miss_ball", bus.ball, xy(324, 303));
    chk("l_miss_score", {12'd0, bus.score}, 20'h10);

    // rally 2: serve goes left; left paddle raised to 131 meets the ball
    bus.p1_up = 1'b1;
    ticks(4);
    bus.p1_up = 1'b0;
    chk("p1_up4", bus.ppos, pp(147, 131));
    ticks(56);
    chk("serve2_hold", bus.ball, xy(324, 303));
    ticks(146);
    chk("l_pad_before", bus.ball, xy(32, 263));
    tick();
    chk("l_pad_hit", bus.ball, xy(32, 265));
    tick();
    chk("l_pad_after", bus.ball, xy(34, 267));
    ticks(302);
    chk("r_miss_before", bus.ball, xy(638, 203));
    tick();
    chk("r_miss_score", {12'd0, bus.score}, 20'h11);
    chk("r_miss_ball", bus.ball, xy(324, 303));

    // rally 3 serve: paddle saturation, then right paddle parked out of the ball's path
    bus.p1_dn = 1'b1;
    ticks(4);
    bus.p1_dn = 1'b0;
    chk("p1_back", bus.ppos, pp(147, 147));
    bus.p1_up = 1'b1; bus.p2_dn = 1'b1;
    ticks(10);
    chk("pad_mid", bus.ppos, pp(187, 107));
    ticks(30);
    chk("pad_sat", bus.ppos, pp(294, 0));
    bus.p1_up = 1'b0; bus.p2_dn = 1'b0;
    ticks(16);
    ticks(157);
    chk("r3_before", {12'd0, bus.score}, 20'h11);
    tick();
    chk("r3_after", {12'd0, bus.score}, 20'h12);
    for (int l = 3; l <= 9; l++) begin
      ticks(217);
      chk("rally_before", {12'd0, bus.score}, {12'd0, 4'h1, 4'(l - 1)});
      tick();
      chk("rally_after", {12'd0, bus.score}, {12'd0, 4'h1, 4'(l)});
    end
    chk("go_set", {19'd0, bus.game_over}, 20'd1);
    chk("go_ball", bus.ball, xy(324, 303));

    // frozen paddles in game over; start beats a coincident tick
    bus.p1_dn = 1'b1; bus.p2_up = 1'b1;
    ticks(3);
    chk("go_frozen", bus.ppos, pp(294, 0));
    chk("go_score", {12'd0, bus.score}, 20'h19);
    @(negedge clk) begin bus.frame_tick = 1'b1; bus.start = 1'b1; end
    @(negedge clk) begin bus.frame_tick = 1'b0; bus.start = 1'b0; end
    chk("start_score", {12'd0, bus.score}, 20'h00);
    chk("start_go", {19'd0, bus.game_over}, 20'd0);
    chk("start_ppos", bus.ppos, pp(294, 0));
    bus.p1_dn = 1'b0; bus.p2_up = 1'b0;
    ticks(60);
    chk("serve3_hold", bus.ball, xy(324, 303));
    tick();
    chk("serve3_move", bus.ball, xy(326, 305));
    ticks(4);
    chk("play_k5", bus.ball, xy(334, 313));

    // asynchronous reset between clock edges
    #1 rst = 1'b1;
    #1;
    chk("arst_ball", bus.ball, xy(324, 303));
    chk("arst_ppos", bus.ppos, pp(147, 147));
    chk("arst_go", {19'd0, bus.game_over}, 20'd0);
    #1 rst = 1'b0;
    ticks(60);
    chk("arst_serve_hold", bus.ball, xy(324, 303));
    tick();
    chk("arst_serve_move", bus.ball, xy(326, 305));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pong_game.md
PONG_GAME -- requirements
Module: pong_game

Interface
REQ-001 Parameter SERVE_FRAMES, default 60: frame ticks spent in SERVE before play begins.
REQ-002 Parameter BALL_SPEED, default 2: ball step per frame on each axis, in pixels.
REQ-003 Parameter PAD_SPEED, default 4: paddle step per frame, in pixels.
REQ-004 Parameter WIN_SCORE, default 9: BCD digit value that ends the game.
REQ-005 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 frame_tick  in  1  one-cycle pulse per frame, issued at vcnt==480, hcnt==0.
REQ-008 start  in  1  level input; when high in GAMEOVER, a new game begins.
REQ-009 p1_up, p1_dn, p2_up, p2_dn  in  1 each  paddle buttons, already synchronised.
REQ-010 ball  out  20  [9:0] x, [19:10] y; ball occupies pixel columns x-7..x-1 and rows y-7..y-1.
REQ-011 ppos  out  20  [9:0] left paddle offset, [19:10] right paddle offset; paddle rows are 129+p..175+p.
REQ-012 score  out  8  [3:0] left player BCD, [7:4] right player BCD.
REQ-013 game_over  out  1  high while in GAMEOVER.

Function
REQ-014 All outputs SHALL be registered, and state SHALL update only in cycles where frame_tick==1, except for the start/reset actions in REQ-024; outputs SHALL reflect the update one clk after the tick.
REQ-015 FSM states: SERVE, PLAY, GAMEOVER.
REQ-016 SERVE: the ball SHALL be held at (x=324, y=303); a frame counter SHALL increment per tick. On the tick where the counter reaches SERVE_FRAMES, the counter SHALL clear and the FSM SHALL enter PLAY. The ball first moves on the next tick.
REQ-017 PLAY, per tick: x_next = x + dx and y_next = y + dy, where dx, dy ∈ {+BALL_SPEED, -BALL_SPEED}. Arithmetic SHALL be 11-bit signed so that no 10-bit wrap occurs before clamping.
REQ-018 Walls:
- if y_next ≤ 137: y = 137 and dy SHALL become positive.
- if y_next ≥ 470: y = 470 and dy SHALL become negative.
REQ-019 Left paddle hit: when dx<0, x_next ≤ 31, x_next > 8, y-1 ≥ 129+p1 and y-7 ≤ 175+p1, then x = 32 and dx SHALL become positive.
REQ-020 Right paddle hit: when dx>0, x_next ≥ 617, x_next < 639, y-1 ≥ 129+p2 and y-7 ≤ 175+p2, then x = 616 and dx SHALL become negative.
REQ-021 Miss:
- x_next ≤ 8: right score SHALL increment; the next serve SHALL have dx negative.
- x_next ≥ 639: left score SHALL increment; the next serve SHALL have dx positive.
- On either miss, the ball SHALL recentre, dy SHALL keep its sign, and the FSM SHALL enter SERVE.
REQ-022 Wall and paddle checks SHALL apply in the same tick, each on its own axis; a corner hit SHALL reflect both dx and dy.
REQ-023 Score: each digit increments in BCD and never exceeds WIN_SCORE. When an increment makes a digit equal WIN_SCORE, the FSM SHALL enter GAMEOVER instead of SERVE, with the ball held at centre.
REQ-024 GAMEOVER: when start==1, on any clk, score SHALL clear to 0, the serve counter SHALL clear, and the FSM SHALL enter SERVE. Ball hold and paddle freeze SHALL remain in force.
REQ-025 Paddles, per tick, in SERVE and PLAY:
- up only: p -= PAD_SPEED, saturating at 0.
- down only: p += PAD_SPEED, saturating at 294.
- both or neither: no change.
- Paddles SHALL be frozen in GAMEOVER.
REQ-026 A simultaneous frame_tick and start in GAMEOVER: start SHALL win, and no paddle motion occurs in that cycle.

Reset
REQ-027 rst SHALL immediately force:
- ball = {y=303, x=324}
- ppos = {147, 147}
- score = 0x00
- game_over = 0
- FSM = SERVE, serve counter = 0
- dx = +BALL_SPEED, dy = +BALL_SPEED
REQ-028 Reset asserted mid-PLAY or mid-GAMEOVER SHALL give the same values as REQ-027. The first tick after release SHALL count as serve frame 1.

Verification
REQ-029 Serve timing: reset, then 60 ticks -> ball stays at (324,303). Tick 61 -> ball = (326,305).
REQ-030 Wall bounce: in PLAY with y=138, dy=-2 -> next tick y=137 and dy=+2. The tick after -> y=139.
REQ-031 Left paddle hit: p1=147, ball y=303, x=33, dx=-2 -> x=32 and dx=+2. Repeat with p1=0 -> left miss path follows: score[7:4] increments and FSM enters SERVE.
REQ-032 Paddle saturation:
- p1_up held for 40 ticks from 147 -> p1 = 0, never wraps.
- p2_dn held for 40 ticks -> p2 = 294.
- p1_up and p1_dn together -> p1 unchanged.
REQ-033 Game over: left score=8, force a right miss -> score[3:0]=9, game_over=1, ball at centre, paddles frozen. Assert start -> score=0x00, game_over=0, SERVE.
REQ-034 Async reset asserted between ticks during PLAY -> outputs reach REQ-027 values within the same cycle, with no clk edge required.
